// File: rtl/gf_bch_pkg.sv
// GF(2^M) helpers for the BCH syndrome path. Every function here is evaluated at
// elaboration to build constant XOR networks.
package gf_bch_pkg;
   localparam int M_MAX   = 16;
   localparam int DEF_N   = 1023;
   localparam int DEF_P   = 1;
   localparam int N_BEATS = DEF_N / DEF_P;
   localparam int CNT_W   = $clog2(N_BEATS + 1);

   typedef logic [M_MAX-1:0] gf_t;
   typedef gf_t [M_MAX-1:0]  gf_mat_t;
   typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} synd_state_e;

   // Primitive polynomial without the x^m term.
   function automatic gf_t gf_prim_poly(input int m);
      case (m)
         3, 4, 6, 7, 15: return gf_t'(16'h0003);
         5, 11:          return gf_t'(16'h0005);
         8:              return gf_t'(16'h001D);
         9:              return gf_t'(16'h0011);
         12:             return gf_t'(16'h0053);
         13:             return gf_t'(16'h001B);
         14:             return gf_t'(16'h0443);
         16:             return gf_t'(16'h100B);
         default:        return gf_t'(16'h0009);
      endcase
   endfunction

   function automatic gf_t gf_xtime(input gf_t a, input int m);
      gf_t mask;
      gf_t r;
      mask = (gf_t'(1) << m) - gf_t'(1);
      r    = (a << 1) & mask;
      if (a[m-1]) r = r ^ gf_prim_poly(m);
      return r;
   endfunction

   function automatic gf_t gf_mult(input gf_t a, input gf_t b, input int m);
      gf_t p;
      p = '0;
      for (int i = M_MAX - 1; i >= 0; i--) begin
         if (i < m) begin
            p = gf_xtime(p, m);
            if (b[i]) p = p ^ a;
         end
      end
      return p;
   endfunction

   function automatic gf_t gf_pow(input int e, input int m);
      gf_t r;
      gf_t base;
      r    = gf_t'(1);
      base = gf_t'(2);
      for (int i = 0; i < 31; i++) begin
         if (((e >> i) & 1) != 0) r = gf_mult(r, base, m);
         base = gf_mult(base, base, m);
      end
      return r;
   endfunction

   // Column i is c * alpha^i, so c*x is the XOR of the columns selected by x.
   function automatic gf_mat_t gf_const_matrix(input gf_t c, input int m);
      gf_mat_t mat;
      for (int i = 0; i < M_MAX; i++)
         mat[i] = (i < m) ? gf_mult(c, gf_pow(i, m), m) : '0;
      return mat;
   endfunction
endpackage

// File: rtl/synd_acc_lane.sv
// One odd-syndrome Horner accumulator: acc <- acc*alpha^(J*P) + sum data[k]*alpha^(J*k).
module synd_acc_lane
   import gf_bch_pkg::*;
#(
   parameter int M = 10,
   parameter int P = 1,
   parameter int J = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         first,
   input  logic [P-1:0] data,
   output logic [M-1:0] acc_d
);
   localparam gf_mat_t STEP_MAT = gf_const_matrix(gf_pow(J * P, M), M);

   logic [M-1:0]         acc_q;
   logic [P-1:0][M-1:0]  in_term;

   for (genvar k = 0; k < P; k++) begin : g_in
      localparam gf_t IN_POW = gf_pow(J * k, M);
      assign in_term[k] = data[k] ? IN_POW[M-1:0] : '0;
   end

   always_comb begin
      acc_d = '0;
      if (!first) begin
         for (int i = 0; i < M; i++)
            if (acc_q[i]) acc_d = acc_d ^ STEP_MAT[i][M-1:0];
      end
      for (int k = 0; k < P; k++)
         acc_d = acc_d ^ in_term[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  acc_q <= '0;
      else if (en) acc_q <= acc_d;
   end
endmodule

// File: rtl/synd_cal_odd_seq.sv
// Sequential odd-syndrome calculator S_1, S_3 .. S_(2T-1) for a BCH codeword over GF(2^M).
//   state    | meaning
//   ST_IDLE  | between codewords; only a first beat is accepted
//   ST_ACCUM | codeword in progress; every valid beat is accumulated
module synd_cal_odd_seq
   import gf_bch_pkg::*;
#(
   parameter int M = 10,
   parameter int T = 3,
   parameter int N = 1023,
   parameter int P = 1
) (
   input  logic           clk,
   input  logic           in_ctr_rstn,
   input  logic           in_valid,
   input  logic           in_first,
   input  logic           in_last,
   input  logic [P-1:0]   in_data,
   output logic           out_valid,
   output logic [T*M-1:0] out_synd,
   output logic           out_err,
   output logic           out_len_err,
   output logic           out_abort
);
   localparam int WORD_BEATS = N / P;
   localparam int CW         = $clog2(WORD_BEATS + 1);
   localparam logic [CW-1:0] WORD_BEATS_C = CW'(WORD_BEATS);

   synd_state_e    state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [T*M-1:0] synd_q, synd_d, synd_nxt;
   logic           valid_q, valid_d, err_q, err_d;
   logic           len_err_q, len_err_d, abort_q, abort_d;
   logic           restart, acc_en, complete;

   for (genvar t = 0; t < T; t++) begin : g_lane
      synd_acc_lane #(.M(M), .P(P), .J(2 * t + 1)) u_lane (
         .clk   (clk),
         .rst_n (in_ctr_rstn),
         .en    (acc_en),
         .first (in_first),
         .data  (in_data),
         .acc_d (synd_nxt[t*M +: M])
      );
   end

   always_comb begin
      restart   = in_valid & in_first;
      acc_en    = in_valid & (in_first | (state_q == ST_ACCUM));
      complete  = acc_en & in_last;
      state_d   = state_q;
      cnt_d     = cnt_q;
      synd_d    = synd_q;
      err_d     = err_q;
      len_err_d = len_err_q;
      valid_d   = complete;
      abort_d   = restart & (state_q == ST_ACCUM);
      if (restart)                   cnt_d = CW'(1);
      else if (acc_en && cnt_q != '1) cnt_d = cnt_q + CW'(1);
      if (complete)     state_d = ST_IDLE;
      else if (restart) state_d = ST_ACCUM;
      // The lanes' next values already include the in_last beat.
      if (complete) begin
         synd_d    = synd_nxt;
         err_d     = |synd_nxt;
         len_err_d = (cnt_d != WORD_BEATS_C);
      end
   end

   always_ff @(posedge clk or negedge in_ctr_rstn) begin
      if (!in_ctr_rstn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         synd_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         len_err_q <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         synd_q    <= synd_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         len_err_q <= len_err_d;
         abort_q   <= abort_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_synd    = synd_q;
   assign out_err     = err_q;
   assign out_len_err = len_err_q;
   assign out_abort   = abort_q;
endmodule

// File: tb/tb_synd_cal_odd_seq.sv
// Directed bench for synd_cal_odd_seq: P=1 and P=3 instances, hand-computed syndromes.
module tb_synd_cal_odd_seq;
   logic        clk = 1'b0;
   logic        rstn;
   logic        v1, f1, l1;
   logic [0:0]  dat1;
   logic        v3, f3, l3;
   logic [2:0]  dat3;
   logic        ov1, oe1, ol1, oa1, ov3, oe3, ol3, oa3;
   logic [29:0] os1, os3;
   int          n_chk = 0, n_pass = 0;
   int          cyc = 0, nv1 = 0, t_prev = 0, t_last = 0, nv_snap;

   synd_cal_odd_seq #(.M(10), .T(3), .N(1023), .P(1)) d1 (
      .clk(clk), .in_ctr_rstn(rstn), .in_valid(v1), .in_first(f1), .in_last(l1),
      .in_data(dat1), .out_valid(ov1), .out_synd(os1), .out_err(oe1),
      .out_len_err(ol1), .out_abort(oa1));

   synd_cal_odd_seq #(.M(10), .T(3), .N(1023), .P(3)) d3 (
      .clk(clk), .in_ctr_rstn(rstn), .in_valid(v3), .in_first(f3), .in_last(l3),
      .in_data(dat3), .out_valid(ov3), .out_synd(os3), .out_err(oe3),
      .out_len_err(ol3), .out_abort(oa3));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (ov1) begin
         nv1++;
         t_prev = t_last;
         t_last = cyc;
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   // One word into the P=1 instance; term=0 leaves it unterminated (no in_last).
   task automatic send1(input int beats, input int deg_a, input int deg_b, input bit gaps,
                        input bit term, input bit exp_abort, input logic [29:0] exp_synd,
                        input bit exp_len, input string tag);
      for (int i = 0; i < beats; i++) begin
         if (gaps && $urandom_range(3) == 0) begin
            v1 = 1'b0;
            @(negedge clk);
         end
         v1      = 1'b1;
         f1      = (i == 0);
         l1      = term && (i == beats - 1);
         dat1[0] = ((1022 - i) == deg_a) || ((1022 - i) == deg_b);
         @(negedge clk);
         if (i == 0) chk({tag, " abort"}, 64'(oa1), 64'(exp_abort));
      end
      if (term) begin
         chk({tag, " valid"}, 64'(ov1), 64'd1);
         chk({tag, " synd"}, 64'(os1), 64'(exp_synd));
         chk({tag, " err"}, 64'(oe1), 64'(exp_synd != 30'd0));
         chk({tag, " len_err"}, 64'(ol1), 64'(exp_len));
      end
   endtask

   task automatic send3(input int deg_a, input int deg_b, input logic [29:0] exp_synd,
                        input string tag);
      int d;
      for (int i = 0; i < 341; i++) begin
         if ($urandom_range(2) == 0) begin
            v3 = 1'b0;
            @(negedge clk);
         end
         v3 = 1'b1;
         f3 = (i == 0);
         l3 = (i == 340);
         for (int k = 0; k < 3; k++) begin
            d       = 1020 - 3 * i + k;
            dat3[k] = (d == deg_a) || (d == deg_b);
         end
         @(negedge clk);
      end
      v3 = 1'b0;
      chk({tag, " valid"}, 64'(ov3), 64'd1);
      chk({tag, " synd"}, 64'(os3), 64'(exp_synd));
      chk({tag, " err"}, 64'(oe3), 64'(exp_synd != 30'd0));
      chk({tag, " len_err"}, 64'(ol3), 64'd0);
   endtask

   initial begin
      rstn = 1'b0;
      v1 = 1'b0; f1 = 1'b0; l1 = 1'b0; dat1 = '0;
      v3 = 1'b0; f3 = 1'b0; l3 = 1'b0; dat3 = '0;
      repeat (3) @(negedge clk);
      chk("rst synd", 64'(os1), 64'd0);
      chk("rst valid", 64'(ov1), 64'd0);
      chk("rst err", 64'(oe1), 64'd0);
      chk("rst len_err", 64'(ol1), 64'd0);
      chk("rst abort", 64'(oa1), 64'd0);
      chk("rst p3 synd", 64'(os3), 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      send1(1023, -1, -1, 0, 1, 0, 30'd0, 0, "zero");
      send1(1023, 0, -1, 0, 1, 0, {10'h001, 10'h001, 10'h001}, 0, "deg0");
      send1(1023, 1, -1, 0, 1, 0, {10'h020, 10'h008, 10'h002}, 0, "deg1");
      send1(1023, 10, -1, 0, 1, 0, {10'h10D, 10'h249, 10'h009}, 0, "deg10");
      send1(1023, 1, 10, 1, 1, 0, {10'h12D, 10'h241, 10'h00B}, 0, "deg1_10 gaps");
      v1 = 1'b0;
      repeat (2) @(negedge clk);

      send3(1, 10, {10'h12D, 10'h241, 10'h00B}, "p3 deg1_10");
      send3(0, -1, {10'h001, 10'h001, 10'h001}, "p3 deg0");
      send3(10, -1, {10'h10D, 10'h249, 10'h009}, "p3 deg10");

      #1 nv_snap = nv1;
      send1(500, -1, -1, 0, 0, 0, 30'd0, 0, "partial");
      send1(1023, -1, -1, 0, 1, 1, 30'd0, 0, "restart");
      v1 = 1'b0;
      @(negedge clk);
      #1 chk("abort valid count", 64'(nv1 - nv_snap), 64'd1);

      send1(1000, -1, -1, 0, 1, 0, 30'd0, 1, "short");
      send1(1023, 0, -1, 0, 1, 0, {10'h001, 10'h001, 10'h001}, 0, "b2b_a");
      send1(1023, 0, -1, 0, 1, 0, {10'h001, 10'h001, 10'h001}, 0, "b2b_b");
      #1 chk("b2b spacing", 64'(t_last - t_prev), 64'd1023);

      nv_snap = nv1;
      send1(300, 1, -1, 0, 0, 0, 30'd0, 0, "pre_rst");
      rstn = 1'b0;
      v1   = 1'b0;
      #1;
      chk("midrst synd", 64'(os1), 64'd0);
      chk("midrst err", 64'(oe1), 64'd0);
      chk("midrst len_err", 64'(ol1), 64'd0);
      chk("midrst valid", 64'(ov1), 64'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (5) @(negedge clk);
      #1 chk("midrst no valid", 64'(nv1 - nv_snap), 64'd0);

      send1(1, -1, -1, 0, 1, 0, 30'd0, 1, "one_beat");
      v1 = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
